piece_scheduler: RTL and testbench

Sequencing controller for falling-block spawns. Produces shapes with a seeded 16-bit LFSR under 7-bag rules, so every group of 7 accepted draws is a permutation of shapes 0–6. Buffers upcoming pieces in a preview FIFO, serves spawn requests from the game FSM with a one-cycle `spawn_valid` pulse, and implements a once-per-spawn hold/swap slot. Sits between the game-control FSM and the playfield/renderer, replacing free-running random shape selection.

---
 rtl/piece_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_piece_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_scheduler.sv
// piece_scheduler: 7-bag shape sequencer with preview FIFO and once-per-spawn hold slot.
// Latency: spawn_valid pulses 1 cycle after the service cycle (2 cycles after a spawn_req rising edge).
// Backpressure: draws stall while the preview FIFO is full; a pending spawn waits while it is empty.
//
// Ports:
//   i_clk, i_reset       single clock, synchronous active-high reset
//   i_spawn_req          request next piece (pulse or level)
//   i_hold_req           request hold/swap of the active piece
//   o_spawn_valid        one-cycle pulse, spawn outputs valid
//   o_spawn_shape/_rotation/_position   registered spawn data
//   o_preview_shape      FIFO head shape, 4'hF when empty
//   o_hold_shape         held shape, 4'hF when empty
//   o_queue_count        FIFO occupancy
//   o_ready              FIFO non-empty
module piece_scheduler #(
    parameter int          QUEUE_DEPTH = 3,
    parameter logic [7:0]  SPAWN_POS   = 8'd128,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_spawn_req,
    input  logic       i_hold_req,
    output logic       o_spawn_valid,
    output logic [3:0] o_spawn_shape,
    output logic [1:0] o_spawn_rotation,
    output logic [7:0] o_spawn_position,
    output logic [3:0] o_preview_shape,
    output logic [3:0] o_hold_shape,
    output logic [2:0] o_queue_count,
    output logic       o_ready
);

    typedef struct packed {
        logic [3:0] shape;
        logic [1:0] rot;
    } entry_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [2:0]  DEPTH3    = 3'(QUEUE_DEPTH);

    logic [15:0] r_lfsr;
    logic [6:0]  r_bag;
    entry_t      r_mem [QUEUE_DEPTH];
    logic [2:0]  r_count;
    logic [3:0]  r_preview;
    logic        r_ready;
    logic        r_req_d;
    logic        r_pending;
    logic        r_active;
    logic        r_hold_used;
    logic [3:0]  r_hold_shape;
    logic        r_spawn_valid;
    logic [3:0]  r_spawn_shape;
    logic [1:0]  r_spawn_rot;

    logic        w_fb;
    logic [2:0]  w_cand;
    logic [7:0]  w_bag8;
    logic [6:0]  w_onehot;
    logic [6:0]  w_bag_or;
    logic [6:0]  w_bag_n;
    logic        w_full;
    logic        w_nonempty;
    logic        w_push;
    logic        w_pop;
    logic        w_arm;
    logic        w_service;
    logic        w_hold_occ;
    logic        w_hold_ok;
    logic        w_hold_fire;
    logic        w_pending_n;
    logic [2:0]  w_wr_idx;
    logic [2:0]  w_count_n;
    entry_t      w_head;
    entry_t      w_new;
    entry_t      w_mem_n [QUEUE_DEPTH];

    // Fibonacci LFSR, taps 16/14/13/11, shifting toward bit 0.
    assign w_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_cand = r_lfsr[2:0];
    assign w_new  = '{shape: {1'b0, w_cand}, rot: r_lfsr[4:3]};

    // Bit 7 is tied high so candidate 7 always looks "already used" and is rejected.
    assign w_bag8     = {1'b1, r_bag};
    assign w_onehot   = 7'(8'h01 << w_cand);
    assign w_bag_or   = r_bag | w_onehot;
    assign w_full     = (r_count == DEPTH3);
    assign w_nonempty = (r_count != 3'd0);
    assign w_push     = !w_full && !w_bag8[w_cand];
    assign w_bag_n    = !w_push ? r_bag : ((w_bag_or == 7'h7F) ? 7'h00 : w_bag_or);

    // A held level request re-arms only in the cycle its previous pulse is visible.
    assign w_arm       = i_spawn_req && (!r_req_d || r_spawn_valid);
    assign w_service   = r_pending && w_nonempty;
    assign w_pending_n = (r_pending && !w_service) || w_arm;

    // Spawn requests take priority over hold in the same cycle.
    assign w_hold_occ  = (r_hold_shape != 4'hF);
    assign w_hold_ok   = i_hold_req && !r_hold_used && r_active && !i_spawn_req && !r_pending;
    assign w_hold_fire = w_hold_ok && (w_hold_occ || w_nonempty);
    assign w_pop       = w_service || (w_hold_fire && !w_hold_occ);

    assign w_head    = r_mem[0];
    assign w_wr_idx  = r_count - {2'b00, w_pop};
    assign w_count_n = r_count + {2'b00, w_push} - {2'b00, w_pop};

    // Shift-register FIFO: head always at index 0; a pop shifts down before the
    // push lands at the first free slot, so push+pop in one cycle returns the old head.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_mem_n[i] = r_mem[i];
        end
        if (w_pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                w_mem_n[i] = r_mem[i + 1];
            end
            w_mem_n[QUEUE_DEPTH - 1] = '0;
        end
        if (w_push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (i == int'(w_wr_idx)) begin
                    w_mem_n[i] = w_new;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr        <= LFSR_INIT;
            r_bag         <= 7'h00;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count       <= 3'd0;
            r_preview     <= 4'hF;
            r_ready       <= 1'b0;
            r_req_d       <= 1'b0;
            r_pending     <= 1'b0;
            r_active      <= 1'b0;
            r_hold_used   <= 1'b0;
            r_hold_shape  <= 4'hF;
            r_spawn_valid <= 1'b0;
            r_spawn_shape <= 4'd0;
            r_spawn_rot   <= 2'd0;
        end else begin
            r_lfsr        <= {w_fb, r_lfsr[15:1]};
            r_bag         <= w_bag_n;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_mem[i] <= w_mem_n[i];
            end
            r_count       <= w_count_n;
            r_preview     <= (w_count_n == 3'd0) ? 4'hF : w_mem_n[0].shape;
            r_ready       <= (w_count_n != 3'd0);
            r_req_d       <= i_spawn_req;
            r_pending     <= w_pending_n;
            r_spawn_valid <= w_service || w_hold_fire;

            if (w_service) begin
                r_spawn_shape <= w_head.shape;
                r_spawn_rot   <= w_head.rot;
                r_active      <= 1'b1;
                r_hold_used   <= 1'b0;
            end else if (w_hold_fire) begin
                r_hold_used  <= 1'b1;
                r_hold_shape <= r_spawn_shape;
                if (w_hold_occ) begin
                    // Swap: the held piece comes back unrotated.
                    r_spawn_shape <= r_hold_shape;
                    r_spawn_rot   <= 2'd0;
                end else begin
                    r_spawn_shape <= w_head.shape;
                    r_spawn_rot   <= w_head.rot;
                end
            end
        end
    end

    assign o_spawn_valid    = r_spawn_valid;
    assign o_spawn_shape    = r_spawn_shape;
    assign o_spawn_rotation = r_spawn_rot;
    assign o_spawn_position = SPAWN_POS;
    assign o_preview_shape  = r_preview;
    assign o_hold_shape     = r_hold_shape;
    assign o_queue_count    = r_count;
    assign o_ready          = r_ready;

endmodule

// File: tb/tb_piece_scheduler.sv
// tb_piece_scheduler: directed bench for piece_scheduler.
// Latency: inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: waits for a full preview FIFO with a bounded cycle budget.
module tb_piece_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       spawn_req;
    logic       hold_req;
    logic       spawn_valid;
    logic [3:0] spawn_shape;
    logic [1:0] spawn_rotation;
    logic [7:0] spawn_position;
    logic [3:0] preview_shape;
    logic [3:0] hold_shape;
    logic [2:0] queue_count;
    logic       ready;

    int n_vec = 0;
    int n_bad = 0;

    // First three accepted draws from seed 16'hACE1 (computed below).
    logic [3:0] q_shape [3];
    logic [1:0] q_rot   [3];

    always #5 clk = ~clk;

    piece_scheduler #(
        .QUEUE_DEPTH(3),
        .SPAWN_POS  (8'd128),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_spawn_req     (spawn_req),
        .i_hold_req      (hold_req),
        .o_spawn_valid   (spawn_valid),
        .o_spawn_shape   (spawn_shape),
        .o_spawn_rotation(spawn_rotation),
        .o_spawn_position(spawn_position),
        .o_preview_shape (preview_shape),
        .o_hold_shape    (hold_shape),
        .o_queue_count   (queue_count),
        .o_ready         (ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for a full preview FIFO.
    task automatic wait_full(input string tag);
        int n = 0;
        while (queue_count != 3'd3 && n < 200) begin
            step();
            n++;
        end
        chk(tag, 32'(queue_count), 32'd3);
    endtask

    // One spawn_req pulse; valid must appear exactly 2 edges later, for one cycle.
    task automatic spawn_pulse(input string tag, output logic [3:0] shp, output logic [1:0] rot);
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        chk({tag, "_early"}, 32'(spawn_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(spawn_valid), 32'd1);
        chk({tag, "_pos"}, 32'(spawn_position), 32'd128);
        shp = spawn_shape;
        rot = spawn_rotation;
        step();
        chk({tag, "_drop"}, 32'(spawn_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] l;
        logic [7:0]  bag;
        logic [2:0]  c;
        logic [3:0]  shp;
        logic [1:0]  rot;
        logic [6:0]  seen1;
        logic [6:0]  seen2;
        logic        prev;
        int          n;
        int          pulses;
        int          consec;

        // Reference draw model: LFSR from seed, 7-bag rejection.
        l   = 16'hACE1;
        bag = 8'h80;
        n   = 0;
        while (n < 3) begin
            c = l[2:0];
            if (!bag[c]) begin
                q_shape[n] = {1'b0, c};
                q_rot[n]   = l[4:3];
                bag[c]     = 1'b1;
                n++;
            end
            l = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
        end

        // Reset state
        reset = 1'b1; spawn_req = 1'b0; hold_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_shape", 32'(spawn_shape), 32'd0);
        chk("rst_rot", 32'(spawn_rotation), 32'd0);
        chk("rst_pos", 32'(spawn_position), 32'd128);
        chk("rst_preview", 32'(preview_shape), 32'hF);
        chk("rst_hold", 32'(hold_shape), 32'hF);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);

        // Spawn + hold right out of reset: spawn waits for the first push, hold ignored
        reset = 1'b0; spawn_req = 1'b1; hold_req = 1'b1;
        step();
        chk("t3_novalid", 32'(spawn_valid), 32'd0);
        chk("t3_cnt_first", 32'(queue_count), 32'd1);
        spawn_req = 1'b0; hold_req = 1'b0;
        step();
        chk("t3_valid", 32'(spawn_valid), 32'd1);
        chk("t3_shape", 32'(spawn_shape), 32'(q_shape[0]));
        chk("t3_rot", 32'(spawn_rotation), 32'(q_rot[0]));
        chk("t3_hold_ign", 32'(hold_shape), 32'hF);
        chk("t3_pushpop_cnt", 32'(queue_count), 32'd1);
        hold_req = 1'b1;
        step();
        chk("t3_hold_valid", 32'(spawn_valid), 32'd1);
        chk("t3_hold_shape", 32'(hold_shape), 32'(q_shape[0]));
        chk("t3_forced_shape", 32'(spawn_shape), 32'(q_shape[1]));
        chk("t3_forced_rot", 32'(spawn_rotation), 32'(q_rot[1]));
        step();
        chk("t3_hold2_novalid", 32'(spawn_valid), 32'd0);
        chk("t3_hold2_hold", 32'(hold_shape), 32'(q_shape[0]));
        chk("t3_hold2_shape", 32'(spawn_shape), 32'(q_shape[1]));
        hold_req = 1'b0;

        // Spawn, then hold with occupied slot: swap
        step();
        spawn_pulse("t4_spawn", shp, rot);
        chk("t4_spawn_shape", 32'(shp), 32'(q_shape[2]));
        chk("t4_spawn_rot", 32'(rot), 32'(q_rot[2]));
        hold_req = 1'b1;
        step();
        hold_req = 1'b0;
        chk("t4_swap_valid", 32'(spawn_valid), 32'd1);
        chk("t4_swap_shape", 32'(spawn_shape), 32'(q_shape[0]));
        chk("t4_swap_rot", 32'(spawn_rotation), 32'd0);
        chk("t4_swap_hold", 32'(hold_shape), 32'(q_shape[2]));
        step();
        chk("t4_swap_drop", 32'(spawn_valid), 32'd0);

        // Reset in the service cycle suppresses the pulse
        wait_full("t6_fill");
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        reset = 1'b1;
        step();
        chk("t6_novalid", 32'(spawn_valid), 32'd0);
        chk("t6_preview", 32'(preview_shape), 32'hF);
        chk("t6_hold", 32'(hold_shape), 32'hF);
        chk("t6_count", 32'(queue_count), 32'd0);
        chk("t6_ready", 32'(ready), 32'd0);
        chk("t6_shape", 32'(spawn_shape), 32'd0);

        // Idle fill
        reset = 1'b0;
        repeat (40) step();
        chk("t1_count", 32'(queue_count), 32'd3);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_preview", 32'(preview_shape), 32'(q_shape[0]));

        // 14 spaced spawns: two complete bags
        seen1 = '0;
        seen2 = '0;
        for (int i = 0; i < 14; i++) begin
            wait_full("t2_fill");
            spawn_pulse("t2", shp, rot);
            if (i < 3) begin
                chk("t2_model_shape", 32'(shp), 32'(q_shape[i]));
                chk("t2_model_rot", 32'(rot), 32'(q_rot[i]));
            end
            chk("t2_range", 32'(shp < 4'd7), 32'd1);
            if (i < 7) seen1 = seen1 | 7'(8'h01 << shp[2:0]);
            else       seen2 = seen2 | 7'(8'h01 << shp[2:0]);
            step();
        end
        chk("t2_perm1", 32'(seen1), 32'h7F);
        chk("t2_perm2", 32'(seen2), 32'h7F);

        // Level-held request: re-arms after each pulse, never back-to-back
        wait_full("t5_fill");
        spawn_req = 1'b1;
        prev   = 1'b0;
        pulses = 0;
        consec = 0;
        repeat (20) begin
            step();
            if (spawn_valid) begin
                pulses++;
                if (prev) consec++;
            end
            prev = spawn_valid;
        end
        spawn_req = 1'b0;
        repeat (4) step();
        chk("t5_consec", 32'(consec), 32'd0);
        chk("t5_min_pulses", 32'(pulses >= 3), 32'd1);
        chk("t5_max_pulses", 32'(pulses <= 10), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
